// File: rtl/ice_spi_pkg.sv
// Shared types and constants for the iCE SPI transfer sequencer.
// State encoding, filler byte and default chip-select timing.
package ice_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SEND,
    ST_WAIT,
    ST_HOLD,
    ST_DONE
  } state_e;

  localparam logic [7:0] FILL_BYTE = 8'hFF;

  localparam int unsigned CS_SETUP_DEF = 4;
  localparam int unsigned CS_HOLD_DEF  = 4;

endpackage

// File: rtl/ice_spi_byte_fifo.sv
// Single-clock byte FIFO with occupancy count.
// A push while full is accepted only when a pop frees a slot the same cycle.
module ice_spi_byte_fifo #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [7:0]    wdata_i,
  input  logic          pop_i,
  output logic [7:0]    rdata_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = mem[rd_ptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      level_d = level_q + (AW+1)'(1);
    else if (!push_ok && pop_ok) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ice_spi_xfer_seq.sv
// SPI transaction sequencer: frames len bytes from a TX FIFO
// under slave select, with setup/hold timing around the burst.
module ice_spi_xfer_seq
  import ice_spi_pkg::*;
#(
  parameter  int unsigned DEPTH    = 16,
  parameter  int unsigned CS_SETUP = CS_SETUP_DEF,
  parameter  int unsigned CS_HOLD  = CS_HOLD_DEF,
  localparam int unsigned LW       = $clog2(DEPTH) + 1
) (
  input  logic          iclk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          start,
  input  logic [7:0]    len,
  output logic          full,
  output logic [LW-1:0] level,
  output logic          ovf,
  output logic          busy,
  output logic          done,
  output logic          rx_valid,
  output logic [7:0]    rx_data,
  output logic          ss_n,
  output logic          m_tx_valid,
  output logic [7:0]    m_tx_data,
  input  logic          m_tx_ready,
  input  logic          m_rx_valid,
  input  logic [7:0]    m_rx_data
);

  state_e     state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_fifo_q, tx_fifo_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       ovf_q, ovf_d;

  logic       accept;
  logic       pop;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;

  ice_spi_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (iclk),
    .rst_i   (rst),
    .push_i  (wr_en),
    .wdata_i (wr_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .level_o (level),
    .full_o  (full),
    .empty_o (fifo_empty)
  );

  assign accept = (state_q == ST_IDLE) && start && (len != 8'd0);
  assign pop    = (state_q == ST_SEND) && m_tx_ready && tx_fifo_q;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    tx_byte_d  = tx_byte_q;
    tx_fifo_d  = tx_fifo_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    ovf_d      = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rem_d   = len;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 8'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = ST_SEND;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SEND: begin
        if (m_tx_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (m_rx_valid) begin
          rx_data_d  = m_rx_data;
          rx_valid_d = 1'b1;
          rem_d      = rem_q - 8'd1;
          state_d    = (rem_q == 8'd1) ? ST_HOLD : ST_SEND;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 8'(CS_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Freeze the offered byte on SEND entry so late pushes cannot alter it
    if (state_d == ST_SEND && state_q != ST_SEND) begin
      tx_fifo_d = ~fifo_empty;
      tx_byte_d = fifo_empty ? FILL_BYTE : fifo_rdata;
    end

    if (accept) ovf_d = 1'b0;
    if (wr_en && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      cnt_q      <= '0;
      tx_byte_q  <= '0;
      tx_fifo_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      tx_byte_q  <= tx_byte_d;
      tx_fifo_q  <= tx_fifo_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign ss_n       = !(state_q == ST_SETUP || state_q == ST_SEND ||
                        state_q == ST_WAIT  || state_q == ST_HOLD);
  assign m_tx_valid = (state_q == ST_SEND);
  assign m_tx_data  = tx_byte_q;
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_ice_spi_xfer_seq.sv
// Bench for ice_spi_xfer_seq: directed steps plus randomized transfers
// checked against a queue model of the FIFO and the framing rules.
module tb_ice_spi_xfer_seq;

  localparam int DEPTH = 16;
  localparam int CSS   = 4;
  localparam int CSH   = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          iclk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          start;
  logic [7:0]    len;
  logic          full;
  logic [LW-1:0] level;
  logic          ovf;
  logic          busy;
  logic          done;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          ss_n;
  logic          m_tx_valid;
  logic [7:0]    m_tx_data;
  logic          m_tx_ready;
  logic          m_rx_valid;
  logic [7:0]    m_rx_data;

  int checks = 0;
  int errs   = 0;

  logic [7:0] q[$];
  bit         movf = 1'b0;

  always #5 iclk = ~iclk;

  ice_spi_xfer_seq #(.DEPTH(DEPTH), .CS_SETUP(CSS), .CS_HOLD(CSH)) dut (
    .iclk       (iclk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .start      (start),
    .len        (len),
    .full       (full),
    .level      (level),
    .ovf        (ovf),
    .busy       (busy),
    .done       (done),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .ss_n       (ss_n),
    .m_tx_valid (m_tx_valid),
    .m_tx_data  (m_tx_data),
    .m_tx_ready (m_tx_ready),
    .m_rx_valid (m_rx_valid),
    .m_rx_data  (m_rx_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
    if (q.size() < DEPTH) q.push_back(b);
    else movf = 1'b1;
    chk("push_level", 32'(level), 32'(q.size()));
    chk("push_full", 32'(full), 32'(q.size() == DEPTH));
    chk("push_ovf", 32'(ovf), 32'(movf));
  endtask

  // One full transaction; master delays drawn from dmin..dmax.
  task automatic run_xfer(input int l, input int dmin, input int dmax,
                          input bit push_hs, input bit poke);
    logic [7:0] exp;
    logic [7:0] rb;
    logic [7:0] pb;
    bit         from_fifo;
    int         d;
    start = 1'b1;
    len   = 8'(l);
    tick();
    start = 1'b0;
    movf  = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < CSS; i++) begin
      chk("setup_ssn", 32'(ss_n), 32'd0);
      chk("setup_txv", 32'(m_tx_valid), 32'd0);
      if (poke && i == 1) begin
        start      = 1'b1;
        len        = 8'd5;
        m_rx_valid = 1'b1;
        m_rx_data  = 8'h77;
      end
      tick();
      start      = 1'b0;
      m_rx_valid = 1'b0;
      if (poke && i == 1) chk("rx_ignored", 32'(rx_valid), 32'd0);
    end
    for (int k = 0; k < l; k++) begin
      from_fifo = (q.size() != 0);
      exp       = from_fifo ? q[0] : 8'hFF;
      d = $urandom_range(dmax, dmin);
      for (int j = 0; j < d; j++) begin
        chk("stall_txv", 32'(m_tx_valid), 32'd1);
        chk("stall_data", 32'(m_tx_data), 32'(exp));
        chk("stall_level", 32'(level), 32'(q.size()));
        tick();
      end
      chk("send_txv", 32'(m_tx_valid), 32'd1);
      chk("send_data", 32'(m_tx_data), 32'(exp));
      chk("send_ssn", 32'(ss_n), 32'd0);
      m_tx_ready = 1'b1;
      pb = 8'($urandom);
      if (push_hs) begin
        wr_en   = 1'b1;
        wr_data = pb;
      end
      tick();
      m_tx_ready = 1'b0;
      wr_en      = 1'b0;
      if (from_fifo) void'(q.pop_front());
      if (push_hs) begin
        if (q.size() < DEPTH) q.push_back(pb);
        else movf = 1'b1;
      end
      chk("wait_txv", 32'(m_tx_valid), 32'd0);
      chk("wait_level", 32'(level), 32'(q.size()));
      chk("wait_ovf", 32'(ovf), 32'(movf));
      d = $urandom_range(dmax, dmin);
      for (int j = 0; j < d; j++) begin
        chk("wait_idle_txv", 32'(m_tx_valid), 32'd0);
        tick();
      end
      rb = 8'($urandom);
      m_rx_valid = 1'b1;
      m_rx_data  = rb;
      tick();
      m_rx_valid = 1'b0;
      chk("rx_valid", 32'(rx_valid), 32'd1);
      chk("rx_data", 32'(rx_data), 32'(rb));
    end
    for (int i = 0; i < CSH; i++) begin
      chk("hold_ssn", 32'(ss_n), 32'd0);
      chk("hold_done", 32'(done), 32'd0);
      chk("hold_txv", 32'(m_tx_valid), 32'd0);
      if (i == 1) chk("rx_pulse_end", 32'(rx_valid), 32'd0);
      tick();
    end
    chk("done_ssn", 32'(ss_n), 32'd1);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    tick();
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_level", 32'(level), 32'(q.size()));
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_data    = '0;
    start      = 1'b0;
    len        = '0;
    m_tx_ready = 1'b0;
    m_rx_valid = 1'b0;
    m_rx_data  = '0;
    #2;
    chk("rst_ssn", 32'(ss_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rxv", 32'(rx_valid), 32'd0);
    chk("rst_rxd", 32'(rx_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_txv", 32'(m_tx_valid), 32'd0);
    @(negedge iclk);
    rst = 1'b0;
    tick();

    push(8'hA5);
    push(8'h3C);
    run_xfer(2, 0, 0, 1'b0, 1'b0);

    run_xfer(3, 0, 2, 1'b0, 1'b0);
    chk("filler_level", 32'(level), 32'd0);

    for (int i = 0; i < DEPTH + 1; i++) push(8'($urandom));
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_level", 32'(level), 32'(DEPTH));
    chk("ovf_set", 32'(ovf), 32'd1);
    run_xfer(1, 0, 0, 1'b1, 1'b0);
    run_xfer(DEPTH, 0, 1, 1'b0, 1'b0);
    chk("drained", 32'(level), 32'd0);

    push(8'h5A);
    run_xfer(1, 10, 10, 1'b0, 1'b0);

    start = 1'b1;
    len   = 8'd0;
    tick();
    start = 1'b0;
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_ssn", 32'(ss_n), 32'd1);
    push(8'hC3);
    run_xfer(2, 0, 1, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++) push(8'($urandom));
    start = 1'b1;
    len   = 8'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < CSS; i++) tick();
    m_tx_ready = 1'b1;
    tick();
    m_tx_ready = 1'b0;
    chk("pre_rst_wait", 32'(m_tx_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_ssn", 32'(ss_n), 32'd1);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    q.delete();
    movf = 1'b0;
    @(negedge iclk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end

    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(20, 0);
      for (int i = 0; i < n; i++) push(8'($urandom));
      run_xfer($urandom_range(24, 1), 0, 3, 1'($urandom_range(1, 0)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
